shift_unit_iter: RTL and testbench

- Parametrised iterative shift unit for the CPU execute stage.
- Generalises the single-cycle SLL/SRL/SRA datapath to any XLEN and any bits-per-cycle step.
- Valid/ready handshakes on input and output, so the CPU can stall on long shifts.
- Used for RV32I/RV64I shift instructions (SLL/SRL/SRA and immediate forms).

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_step.sv | 49 ++++
 rtl/shift_unit_iter.sv | 166 ++++++++++++++++
 tb/tb_shift_unit_iter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared types for the iterative shift unit.
//   - shift_op_e    : operation encodings carried on the 2-bit op input
//   - shift_state_e : FSM states of shift_unit_iter
//   Build option: SHIFT_UNIT_ROTATE_EN selects whether OP_ROR rotates
//   (defined) or is a reserved pass-through (undefined). The encodings are
//   the same in both builds.
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Purely combinational single-step shifter used by shift_unit_iter while it
//   is in the SHIFT state. Shifts acc by d (0..STEP) according to op.
//
//   Parameters
//     XLEN : operand width in bits
//     STEP : largest distance d will ever carry
//   Ports
//     acc      in  XLEN              value being shifted
//     op       in  shift_op_e        SLL / SRL / SRA / ROR
//     d        in  $clog2(STEP)+1    distance for this step
//     next_acc out XLEN              acc shifted by d
//
//   Build option: SHIFT_UNIT_ROTATE_EN enables the OP_ROR rotate path.
//   Without it OP_ROR passes acc through unchanged (the top never issues a
//   non-zero step for that op in that build anyway).
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [XLEN-1:0]          acc,
  input  shift_op_e                op,
  input  logic [$clog2(STEP):0]    d,
  output logic [XLEN-1:0]          next_acc
);

  // NOTE: every signal written in an always_comb gets a default on entry;
  // any path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    next_acc = acc;
    case (op)
      OP_SLL: next_acc = acc << d;
      OP_SRL: next_acc = acc >> d;
      // The acc MSB is still the original sign bit because SRA only ever
      // replicates it, so each partial step sign-extends correctly.
      OP_SRA: next_acc = $signed(acc) >>> d;
`ifdef SHIFT_UNIT_ROTATE_EN
      // Shifting by XLEN (d == 0) yields zero, so d == 0 is a clean no-op.
      OP_ROR: next_acc = (acc >> d) | (acc << (XLEN - int'(d)));
`endif
      default: next_acc = acc;
    endcase
  end

endmodule : shift_step

// File: rtl/shift_unit_iter.sv
// -----------------------------------------------------------------------------
// shift_unit_iter
//   Iterative shift unit for the execute stage (RV32I/RV64I SLL/SRL/SRA and
//   immediate forms). Applies up to STEP bits of shift per cycle so the
//   datapath stays small for large XLEN; valid/ready handshakes on both sides
//   let the pipeline stall on long shifts.
//
//   Parameters
//     XLEN    : operand/result width (power of 2, >= 8)
//     STEP    : maximum shift per SHIFT cycle (power of 2, 1..XLEN/2)
//     SHAMT_W : shift-amount width, fixed to $clog2(XLEN)
//   Ports
//     clk       in   rising-edge clock
//     reset     in   asynchronous, active-high reset
//     in_valid  in   request presented
//     in_ready  out  unit idle and able to accept (decode of state only)
//     op        in   00 SLL, 01 SRL, 11 SRA, 10 ROR / pass-through
//     operand   in   value to shift
//     shamt     in   unsigned shift amount
//     out_valid out  registered, result available
//     out_ready in   consumer takes the result
//     result    out  registered shifted value, held after the transfer
//     busy      out  high in SHIFT or DONE
//
//   Build option: SHIFT_UNIT_ROTATE_EN
//     defined   : op 10 rotates right, same latency as the shifts
//     undefined : op 10 returns operand unchanged with one-cycle latency
//
//   Timing: a request accepted at edge N raises out_valid after edge
//   N+1+ceil(shamt/STEP). The first DONE cycle loads result/out_valid from
//   acc; the transfer then happens on any later DONE edge with out_ready.
// -----------------------------------------------------------------------------
module shift_unit_iter
  import shift_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               busy
);

  localparam int                 DW       = $clog2(STEP) + 1;
  localparam logic [SHAMT_W-1:0] STEP_REM = SHAMT_W'(STEP);

  shift_state_e       state;
  shift_state_e       state_next;
  shift_op_e          op_q;
  logic [XLEN-1:0]    acc;
  logic [XLEN-1:0]    step_acc;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] shamt_eff;
  logic [DW-1:0]      d;
  logic               accept;
  logic               last_step;
  logic               load_out;
  logic               take;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_ready && in_valid;

  // First DONE cycle publishes acc; later DONE cycles wait for out_ready.
  assign load_out = (state == ST_DONE) && !out_valid;
  assign take     = (state == ST_DONE) && out_valid && out_ready;

  // Without the rotate option op 10 is a pass-through: no shift cycles.
`ifdef SHIFT_UNIT_ROTATE_EN
  assign shamt_eff = shamt;
`else
  assign shamt_eff = (op == OP_ROR) ? '0 : shamt;
`endif

  // ---------------------------------------------------------------------------
  // Per-cycle distance: d = min(STEP, rem). DW never exceeds SHAMT_W because
  // STEP <= XLEN/2, so the slice of rem is always legal.
  // ---------------------------------------------------------------------------
  assign d         = (rem < STEP_REM) ? rem[DW-1:0] : DW'(STEP);
  assign last_step = (rem <= STEP_REM);

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .acc      (acc),
    .op       (op_q),
    .d        (d),
    .next_acc (step_acc)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (shamt_eff == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (take) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_SLL;
      rem       <= '0;
      // NOTE: acc is a single working register, not a memory array, so it is
      // reset along with the rest; it is also fully reloaded on every accept.
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      state <= state_next;

      if (accept) begin
        acc  <= operand;
        op_q <= shift_op_e'(op);
        rem  <= shamt_eff;
      end else if (state == ST_SHIFT) begin
        acc <= step_acc;
        rem <= rem - SHAMT_W'(d);
      end

      if (load_out) begin
        out_valid <= 1'b1;
        result    <= acc;
      end else if (take) begin
        // result intentionally keeps its last value after the transfer
        out_valid <= 1'b0;
      end
    end
  end

endmodule : shift_unit_iter

// File: tb/tb_shift_unit_iter.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_iter
//   Directed bench for shift_unit_iter. Instance 0 uses STEP=1, instance 1
//   uses STEP=4; both XLEN=32. Expected values are hand-computed constants.
//   Honours SHIFT_UNIT_ROTATE_EN for the op 10 expectations.
// -----------------------------------------------------------------------------
module tb_shift_unit_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [1:0]  op        [2];
  logic [31:0] operand   [2];
  logic [4:0]  shamt     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] result    [2];
  logic        busy      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_unit_iter #(.XLEN(32), .STEP(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .op        (op[0]),
    .operand   (operand[0]),
    .shamt     (shamt[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .result    (result[0]),
    .busy      (busy[0])
  );

  shift_unit_iter #(.XLEN(32), .STEP(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .op        (op[1]),
    .operand   (operand[1]),
    .shamt     (shamt[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .result    (result[1]),
    .busy      (busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid; returns the number of edges since accept.
  task automatic wait_valid(input int u, output int cycles);
    cycles = 0;
    while (out_valid[u] !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  // Issue one request, scramble inputs after acceptance, check latency and
  // result, then complete the output transfer.
  task automatic run_op(input int u, input logic [1:0] o, input logic [31:0] val,
                        input logic [4:0] sh, input logic [31:0] exp_res,
                        input int exp_lat, input string tag);
    int cycles;
    check({tag, " in_ready"}, 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    op[u]       = o;
    operand[u]  = val;
    shamt[u]    = sh;
    tick();
    in_valid[u] = 1'b0;
    op[u]       = ~o;
    operand[u]  = ~val;
    shamt[u]    = sh + 5'd1;
    wait_valid(u, cycles);
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " result"}, result[u], exp_res);
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid[u]), 32'd0);
    check({tag, " back to idle"}, 32'(in_ready[u]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles;
    logic [31:0] held;

    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      op[u]        = 2'b00;
      operand[u]   = '0;
      shamt[u]     = '0;
      out_ready[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  32'(in_ready[0]),  32'd1);
    check("reset out_valid", 32'(out_valid[0]), 32'd0);
    check("reset busy",      32'(busy[0]),      32'd0);
    check("reset result",    result[0],         32'd0);
    check("reset4 result",   result[1],         32'd0);
    #3 reset = 1'b0;
    tick();

    // STEP=1 directed vectors
    run_op(0, 2'b11, 32'h0000_0040, 5'd4,  32'h0000_0004, 5,  "sra 0x40>>4");
    run_op(0, 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32, "sra min>>31");
    run_op(0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 32, "srl msb>>31");
    run_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, "sll lsb<<31");
    run_op(0, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  "sll by 0");

    // STEP=4 directed vectors (ceil(shamt/4) shift cycles)
    run_op(1, 2'b11, 32'hF000_0000, 5'd13, 32'hFFFF_8000, 5,  "step4 sra 13");
    run_op(1, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9,  "step4 sll 31");
    run_op(1, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 2,  "step4 srl 4");

    // op 10: rotate or pass-through depending on build
`ifdef SHIFT_UNIT_ROTATE_EN
    run_op(0, 2'b10, 32'h0000_0001, 5'd1, 32'h8000_0000, 2, "ror 1");
    run_op(1, 2'b10, 32'h1234_5678, 5'd8, 32'h7812_3456, 3, "step4 ror 8");
`else
    run_op(0, 2'b10, 32'h0000_0001, 5'd1, 32'h0000_0001, 1, "pass op10");
    run_op(1, 2'b10, 32'h1234_5678, 5'd8, 32'h1234_5678, 1, "step4 pass op10");
`endif

    // Backpressure: hold the result in DONE, ignore new requests
    in_valid[0] = 1'b1;
    op[0]       = 2'b01;
    operand[0]  = 32'hA5A5_A5A5;
    shamt[0]    = 5'd3;
    tick();
    in_valid[0] = 1'b0;
    wait_valid(0, cycles);
    check("bp latency", 32'(cycles), 32'd4);
    check("bp result", result[0], 32'h14B4_B4B4);
    held = 32'h14B4_B4B4;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_valid[0] = 1'b1;
        op[0]       = 2'b00;
        operand[0]  = 32'hFFFF_FFFF;
        shamt[0]    = 5'd0;
      end else begin
        in_valid[0] = 1'b0;
      end
      tick();
      check("bp hold result",    result[0],          held);
      check("bp hold out_valid", 32'(out_valid[0]),  32'd1);
      check("bp hold in_ready",  32'(in_ready[0]),   32'd0);
    end
    // Release with a simultaneous request: the request must not be taken.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    operand[0]   = 32'h0BAD_F00D;
    tick();
    in_valid[0] = 1'b0;
    check("bp release out_valid", 32'(out_valid[0]), 32'd0);
    check("bp release busy",      32'(busy[0]),      32'd0);
    check("bp release result",    result[0],         held);
    // out_ready outside DONE has no effect
    tick();
    out_ready[0] = 1'b0;
    check("idle out_ready busy",      32'(busy[0]),      32'd0);
    check("idle out_ready out_valid", 32'(out_valid[0]), 32'd0);

    // Reset in the middle of a 20-bit shift
    in_valid[0] = 1'b1;
    op[0]       = 2'b00;
    operand[0]  = 32'h0000_0003;
    shamt[0]    = 5'd20;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    check("mid-shift busy", 32'(busy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset in_ready",  32'(in_ready[0]),  32'd1);
    check("async reset out_valid", 32'(out_valid[0]), 32'd0);
    check("async reset busy",      32'(busy[0]),      32'd0);
    check("async reset result",    result[0],         32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post reset idle", 32'(in_ready[0]), 32'd1);
    run_op(0, 2'b01, 32'h1234_5678, 5'd8, 32'h0012_3456, 9, "srl after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shift_unit_iter
